// File: rtl/text_pkg.sv
// Shared definitions for the text-mode character RAM (1024x16).
// Used by the console writer and by the VGA renderer.
//   - screen geometry (COLS, ROWS, STRIDE), blank character, address width
//   - control codes understood by the writer
//   - cell word layout: attr in [15:8], char in [7:0]
//   - writer FSM state encoding
package text_pkg;

    localparam int unsigned COLS       = 30;
    localparam int unsigned ROWS       = 17;
    localparam int unsigned STRIDE     = 32;
    localparam logic [7:0]  BLANK_CHAR = 8'h20;
    localparam int unsigned AW         = 10;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    // One RAM word; packed so that attr lands in [15:8] and char in [7:0].
    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] ch;
    } cell_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLRLINE = 2'd1,
        ST_CLRSCR  = 2'd2
    } state_t;

    function automatic cell_t make_cell(input logic [7:0] a, input logic [7:0] c);
        cell_t w;
        w.attr = a;
        w.ch   = c;
        return w;
    endfunction

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_LO) && (c <= PRINT_HI);
    endfunction

endpackage

// File: rtl/text_addr_gen.sv
// Maps a (row, col) pair to the character RAM address row*STRIDE + col.
// A power-of-two STRIDE becomes a shift; other strides fall back to a multiply.
// Ports:
//   row  in  ROW_W  row index
//   col  in  AW     column / offset within the row
//   addr out AW     RAM word address
module text_addr_gen #(
    parameter int unsigned AW     = 10,
    parameter int unsigned STRIDE = 32,
    parameter int unsigned ROW_W  = 5
) (
    input  logic [ROW_W-1:0] row,
    input  logic [AW-1:0]    col,
    output logic [AW-1:0]    addr
);

    localparam bit          POW2  = ((STRIDE & (STRIDE - 1)) == 0);
    localparam int unsigned SHIFT = $clog2(STRIDE);

    generate
        if (POW2) begin : g_shift
            assign addr = (AW'(row) << SHIFT) + col;
        end else begin : g_mul
            assign addr = AW'(AW'(row) * AW'(STRIDE)) + col;
        end
    endgenerate

endmodule

// File: rtl/text_console_writer.sv
// Write-side producer for the text-mode character RAM.
// Consumes a byte stream (printables and control codes), tracks a cursor and
// issues registered single-cycle writes of {attr, char} to the RAM write port.
// Handles auto-wrap, line clear on newline and full-screen clear.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   char_valid/ready  byte handshake; char_data is the byte, attr its colour
//   clear_req         one-cycle request to clear the screen (IDLE only)
//   ram_cea/ada/din   registered RAM write port, one cea pulse per word
//   cursor_col/row    current cursor position
//   busy              high while a line or screen clear is in progress
module text_console_writer #(
    parameter int unsigned COLS       = text_pkg::COLS,
    parameter int unsigned ROWS       = text_pkg::ROWS,
    parameter int unsigned STRIDE     = text_pkg::STRIDE,
    parameter logic [7:0]  BLANK_CHAR = text_pkg::BLANK_CHAR,
    parameter int unsigned AW         = text_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          char_valid,
    input  logic [7:0]    char_data,
    output logic          char_ready,
    input  logic [7:0]    attr,
    input  logic          clear_req,
    output logic          ram_cea,
    output logic [AW-1:0] ram_ada,
    output logic [15:0]   ram_din,
    output logic [4:0]    cursor_col,
    output logic [4:0]    cursor_row,
    output logic          busy
);

    import text_pkg::*;

    localparam logic [4:0]    COL_LAST  = 5'(COLS - 1);
    localparam logic [4:0]    ROW_LAST  = 5'(ROWS - 1);
    localparam logic [AW-1:0] LINE_LAST = AW'(STRIDE - 1);
    localparam logic [AW-1:0] SCR_LAST  = AW'(ROWS * STRIDE - 1);

    state_t        state_q, state_d;
    logic [4:0]    col_q, col_d;
    logic [4:0]    row_q, row_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [7:0]    clr_attr_q, clr_attr_d;
    logic          ram_cea_q, ram_cea_d;
    logic [AW-1:0] ram_ada_q, ram_ada_d;
    logic [15:0]   ram_din_q, ram_din_d;

    logic [AW-1:0] gen_col;
    logic [AW-1:0] gen_addr;
    logic          accept;

    // One address generator serves both the cursor write (IDLE) and the
    // line clear, where the clear counter stands in for the column.
    assign gen_col = (state_q == ST_CLRLINE) ? cnt_q : AW'(col_q);

    text_addr_gen #(
        .AW     (AW),
        .STRIDE (STRIDE),
        .ROW_W  (5)
    ) u_addr_gen (
        .row  (row_q),
        .col  (gen_col),
        .addr (gen_addr)
    );

    assign char_ready = (state_q == ST_IDLE) && !clear_req;
    assign accept     = char_valid && char_ready;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        clr_attr_d = clr_attr_q;
        ram_cea_d  = 1'b0;
        ram_ada_d  = ram_ada_q;
        ram_din_d  = ram_din_q;

        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d    = ST_CLRSCR;
                    cnt_d      = '0;
                    clr_attr_d = attr;
                end else if (accept) begin
                    if (is_printable(char_data)) begin
                        ram_cea_d = 1'b1;
                        ram_ada_d = gen_addr;
                        ram_din_d = make_cell(attr, char_data);
                        if (col_q == COL_LAST) begin
                            // Auto-wrap: this write goes out now, the clear of
                            // the next row starts on the following cycle.
                            col_d      = '0;
                            row_d      = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
                            state_d    = ST_CLRLINE;
                            cnt_d      = '0;
                            clr_attr_d = attr;
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                    end else if (char_data == CC_CR) begin
                        col_d = '0;
                    end else if (char_data == CC_LF) begin
                        col_d      = '0;
                        row_d      = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
                        state_d    = ST_CLRLINE;
                        cnt_d      = '0;
                        clr_attr_d = attr;
                    end else if (char_data == CC_BS) begin
                        if (col_q != 5'd0) begin
                            col_d = col_q - 5'd1;
                        end
                    end else if (char_data == CC_FF) begin
                        state_d    = ST_CLRSCR;
                        cnt_d      = '0;
                        clr_attr_d = attr;
                    end
                end
            end

            ST_CLRLINE: begin
                ram_cea_d = 1'b1;
                ram_ada_d = gen_addr;
                ram_din_d = make_cell(clr_attr_q, BLANK_CHAR);
                if (cnt_q == LINE_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_CLRSCR: begin
                ram_cea_d = 1'b1;
                ram_ada_d = cnt_q;
                ram_din_d = make_cell(clr_attr_q, BLANK_CHAR);
                if (cnt_q == SCR_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            clr_attr_q <= '0;
            ram_cea_q  <= 1'b0;
            ram_ada_q  <= '0;
            ram_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            clr_attr_q <= clr_attr_d;
            ram_cea_q  <= ram_cea_d;
            ram_ada_q  <= ram_ada_d;
            ram_din_q  <= ram_din_d;
        end
    end

    assign ram_cea    = ram_cea_q;
    assign ram_ada    = ram_ada_q;
    assign ram_din    = ram_din_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer with default geometry
// (30 cols, 17 rows, stride 32, blank 0x20).
module tb_text_console_writer;

    logic        clk;
    logic        reset;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic [7:0]  attr;
    logic        clear_req;
    logic        ram_cea;
    logic [9:0]  ram_ada;
    logic [15:0] ram_din;
    logic [4:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned bad_addr = 0;

    logic [9:0]  log_ada[$];
    logic [15:0] log_din[$];

    text_console_writer #(
        .COLS       (30),
        .ROWS       (17),
        .STRIDE     (32),
        .BLANK_CHAR (8'h20),
        .AW         (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .attr       (attr),
        .clear_req  (clear_req),
        .ram_cea    (ram_cea),
        .ram_ada    (ram_ada),
        .ram_din    (ram_din),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write logger: every word presented on the RAM port.
    always @(negedge clk) begin
        if (ram_cea) begin
            log_ada.push_back(ram_ada);
            log_din.push_back(ram_din);
            if (ram_ada >= 10'd544) bad_addr++;
        end
    end

    typedef struct {
        logic [7:0]  data;
        logic [7:0]  a;
        logic [4:0]  col;
        logic [4:0]  row;
        int unsigned nwr;
        logic [9:0]  ada;
        logic [15:0] din;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            $display("FAIL idle_wait: busy still 1 after %0d cycles, expected 0", n);
        end
    endtask

    // Returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input logic [7:0] a);
        wait_idle();
        char_valid = 1'b1;
        char_data  = b;
        attr       = a;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic check_cursor(input string name, input logic [4:0] r, input logic [4:0] c);
        check({name, "_row"}, 32'(cursor_row), 32'(r));
        check({name, "_col"}, 32'(cursor_col), 32'(c));
    endtask

    initial begin
        int unsigned errs;
        int unsigned berrs;

        reset      = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        attr       = 8'h07;
        clear_req  = 1'b0;

        vecs[0]  = '{8'h0D, 8'h07, 5'd0, 5'd0, 0,  10'd0,  16'h0000};
        vecs[1]  = '{8'h0A, 8'h07, 5'd0, 5'd1, 32, 10'd63, 16'h0720};
        vecs[2]  = '{8'h0A, 8'h1E, 5'd0, 5'd2, 32, 10'd95, 16'h1E20};
        vecs[3]  = '{8'h78, 8'h07, 5'd1, 5'd2, 1,  10'd64, 16'h0778};
        vecs[4]  = '{8'h08, 8'h07, 5'd0, 5'd2, 0,  10'd0,  16'h0000};
        vecs[5]  = '{8'h08, 8'h07, 5'd0, 5'd2, 0,  10'd0,  16'h0000};
        vecs[6]  = '{8'h07, 8'h07, 5'd0, 5'd2, 0,  10'd0,  16'h0000};
        vecs[7]  = '{8'h7F, 8'h07, 5'd0, 5'd2, 0,  10'd0,  16'h0000};
        vecs[8]  = '{8'h1F, 8'h07, 5'd0, 5'd2, 0,  10'd0,  16'h0000};
        vecs[9]  = '{8'h7E, 8'h42, 5'd1, 5'd2, 1,  10'd64, 16'h427E};
        vecs[10] = '{8'h20, 8'h07, 5'd2, 5'd2, 1,  10'd65, 16'h0720};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cea", 32'(ram_cea), 32'd0);
        check("rst_ada", 32'(ram_ada), 32'd0);
        check("rst_din", 32'(ram_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(char_ready), 32'd1);
        check_cursor("rst", 5'd0, 5'd0);
        @(negedge clk);
        reset = 1'b0;

        // First write: one cycle after acceptance
        send_byte(8'h41, 8'h07);
        check("a_cea", 32'(ram_cea), 32'd1);
        check("a_ada", 32'(ram_ada), 32'd0);
        check("a_din", 32'(ram_din), 32'h0741);
        check_cursor("a", 5'd0, 5'd1);
        @(posedge clk);
        #1;
        check("a_cea_pulse", 32'(ram_cea), 32'd0);

        // Table of single bytes
        for (int i = 0; i < 11; i++) begin
            wait_idle();
            #1;
            log_ada.delete();
            log_din.delete();
            send_byte(vecs[i].data, vecs[i].a);
            wait_idle();
            #1;
            check($sformatf("vec%0d_nwr", i), 32'(log_ada.size()), 32'(vecs[i].nwr));
            check_cursor($sformatf("vec%0d", i), vecs[i].row, vecs[i].col);
            if (vecs[i].nwr != 0 && log_ada.size() != 0) begin
                check($sformatf("vec%0d_ada", i), 32'(log_ada[log_ada.size()-1]), 32'(vecs[i].ada));
                check($sformatf("vec%0d_din", i), 32'(log_din[log_din.size()-1]), 32'(vecs[i].din));
            end
        end

        // Back-to-back printables: col 2 -> 29 on row 2
        wait_idle();
        log_ada.delete();
        log_din.delete();
        char_valid = 1'b1;
        char_data  = 8'h61;
        attr       = 8'h07;
        errs = 0;
        for (int i = 0; i < 27; i++) begin
            #1;
            if (!char_ready) errs++;
            @(posedge clk);
            @(negedge clk);
        end
        char_valid = 1'b0;
        check("burst_ready", errs, 0);
        #1;
        check("burst_nwr", 32'(log_ada.size()), 32'd27);
        check_cursor("burst", 5'd2, 5'd29);

        // Auto-wrap from the last column
        send_byte(8'h5A, 8'h07);
        check("wrap_cea", 32'(ram_cea), 32'd1);
        check("wrap_ada", 32'(ram_ada), 32'd93);
        check("wrap_din", 32'(ram_din), 32'h075A);
        errs = 0;
        berrs = 0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            if (!(ram_cea && ram_ada == 10'(96 + i) && ram_din == 16'h0720)) errs++;
            if (i < 31 && !busy) berrs++;
        end
        check("wrap_clr_words", errs, 0);
        check("wrap_busy", berrs, 0);
        @(posedge clk);
        #1;
        check("wrap_cea_end", 32'(ram_cea), 32'd0);
        check_cursor("wrap", 5'd3, 5'd0);

        // Newline from the bottom row wraps to row 0
        for (int i = 0; i < 13; i++) send_byte(8'h0A, 8'h07);
        wait_idle();
        #1;
        check_cursor("lf16", 5'd16, 5'd0);
        log_ada.delete();
        log_din.delete();
        send_byte(8'h0A, 8'h07);
        wait_idle();
        #1;
        check_cursor("lfwrap", 5'd0, 5'd0);
        check("lfwrap_nwr", 32'(log_ada.size()), 32'd32);
        errs = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < log_ada.size()) begin
                if (log_ada[i] != 10'(i) || log_din[i] != 16'h0720) errs++;
            end
        end
        check("lfwrap_words", errs, 0);

        // clear_req beats a simultaneous byte
        send_byte(8'h71, 8'h07);
        wait_idle();
        clear_req  = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h51;
        attr       = 8'h1F;
        #1;
        check("clr_ready_low", 32'(char_ready), 32'd0);
        @(posedge clk);
        #1;
        clear_req  = 1'b0;
        char_valid = 1'b0;
        attr       = 8'h07;
        check("clr_no_byte_write", 32'(ram_cea), 32'd0);
        errs = 0;
        berrs = 0;
        for (int i = 0; i < 544; i++) begin
            @(posedge clk);
            #1;
            if (!(ram_cea && ram_ada == 10'(i) && ram_din == 16'h1F20)) errs++;
            if (i < 543 && char_ready) berrs++;
        end
        check("clr_words", errs, 0);
        check("clr_ready_busy", berrs, 0);
        check("clr_ready_done", 32'(char_ready), 32'd1);
        check_cursor("clr", 5'd0, 5'd0);
        @(posedge clk);
        #1;
        check("clr_cea_end", 32'(ram_cea), 32'd0);

        // BS at col 0, CR, and an ignored code: no writes, cursor unchanged
        for (int i = 0; i < 5; i++) send_byte(8'h0A, 8'h07);
        wait_idle();
        #1;
        log_ada.delete();
        log_din.delete();
        send_byte(8'h08, 8'h07);
        send_byte(8'h0D, 8'h07);
        send_byte(8'h07, 8'h07);
        wait_idle();
        #1;
        check("ctl_nwr", 32'(log_ada.size()), 32'd0);
        check_cursor("ctl", 5'd5, 5'd0);

        // Reset in the middle of a screen clear
        send_byte(8'h0C, 8'h07);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
        end
        check("mid_cea", 32'(ram_cea), 32'd1);
        check("mid_ada", 32'(ram_ada), 32'd99);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cea", 32'(ram_cea), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(char_ready), 32'd1);
        check_cursor("abort", 5'd0, 5'd0);
        reset = 1'b0;
        send_byte(8'h41, 8'h07);
        check("post_ada", 32'(ram_ada), 32'd0);
        check("post_din", 32'(ram_din), 32'h0741);

        check("addr_range", bad_addr, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time exceeded, required finish");
        $fatal(1);
    end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Write-side producer for the 1024x16 text-mode character RAM.
- Accepts a byte stream of characters and control codes over a valid/ready handshake.
- Tracks a cursor and issues single-cycle writes of {attr, char} words to the RAM write port. Handles wrap, line clear and full-screen clear.
- Sits between the CPU/UART front end and the RAM's write port. The VGA renderer reads the read port independently.

Parameters:
- COLS, 30, visible columns per row.
- ROWS, 17, visible rows.
- STRIDE, 32, words per row in RAM; address = row*STRIDE + col.
- BLANK_CHAR, 8'h20, character code written when clearing.
- AW, 10, RAM address width.

Ports:
- clk  in  1  system clock; same clock drives the RAM write port.
- reset  in  1  synchronous, active-high.
- char_valid  in  1  char_data is valid.
- char_data  in  8  character or control code.
- char_ready  out  1  block can accept a byte this cycle.
- attr  in  8  colour attribute. Sampled with each accepted byte and at clear start.
- clear_req  in  1  one-cycle request to clear the screen.
- ram_cea  out  1  RAM write enable, one pulse per word.
- ram_ada  out  AW  RAM write address.
- ram_din  out  16  RAM write data = {attr, char}.
- cursor_col  out  5  current column, 0..COLS-1.
- cursor_row  out  5  current row, 0..ROWS-1.
- busy  out  1  high in CLRLINE or CLRSCR.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - state=IDLE; cursor 0,0.
  - ram_cea=0, ram_ada=0, ram_din=0.
  - busy=0.
  - RAM contents are untouched, so the initial screen image survives reset.
- RAM outputs: all are registered. A write appears on ram_cea/ram_ada/ram_din exactly one cycle after the accepting edge. ram_cea is 1 for exactly one cycle per word.
- char_ready = (state==IDLE) && !clear_req. A byte is accepted on a cycle with char_valid && char_ready.
- States:
  - IDLE: accept bytes or clear_req.
  - CLRLINE: write STRIDE blank words of cursor_row, one per cycle, addresses row*STRIDE .. row*STRIDE+STRIDE-1. Then go to IDLE.
  - CLRSCR: write blanks to addresses 0 .. ROWS*STRIDE-1 (544 words with defaults), one per cycle. Then set cursor to 0,0 and go to IDLE.
- Accepted byte handling in IDLE:
  - 0x20..0x7E printable: write {attr, char} at the cursor, then col+1. If the new col reaches COLS, perform a newline. Back-to-back printables are accepted every cycle while no newline occurs.
  - 0x0D CR: col=0. No write.
  - 0x0A LF newline: col=0, row+1. If row was ROWS-1, row=0 (wrap, no scroll). Then enter CLRLINE for the new row.
  - 0x08 BS: if col>0, col-1; no write. At col 0, no change.
  - 0x0C FF: enter CLRSCR.
  - Any other code: ignored, consumed.
- Blank word: {attr latched at the start of the clear, BLANK_CHAR}.
- Auto-wrap: the last-column write is issued first; CLRLINE of the next row then follows with no bubble.
- Simultaneous events:
  - clear_req and char_valid together in IDLE: clear wins and the byte is not accepted.
  - clear_req outside IDLE is ignored.
- Reset mid-clear: aborts immediately. The next cycle has ram_cea=0, cursor 0,0, state IDLE. Partially cleared RAM is left as is.
- Arithmetic: the clear counter is AW bits and terminates at count==limit-1, never wrapping past limit. Cursor arithmetic is unsigned with explicit compares; no modulo.

Decomposition:
- Shared package text_pkg holds:
  - COLS, ROWS, STRIDE, BLANK_CHAR.
  - Control-code constants CC_CR, CC_LF, CC_BS, CC_FF.
  - The cell word layout: attr in [15:8], char in [7:0].
  - State encoding.
  - These are also used by the VGA renderer.
- One sub-module, text_addr_gen: maps (row, col) to row*STRIDE+col as a shift when STRIDE is a power of two. Shared with the renderer.

Test Plan:
1. Reset, then send 'A' (0x41) with attr 0x07 → one cycle later ram_cea=1, ada=0, din=0x0741; cursor 0,1.
2. Cursor at row 2 col 29, send 'Z' → write ada=93 din=0x075A, then 32 writes ada=96..127 din=0x0720, busy=1 throughout; final cursor 3,0.
3. Cursor at row 16, send 0x0A → cursor 0,0, clears ada=0..31; no write to ada≥544.
4. Pulse clear_req with char_valid=1 and attr 0x1F → byte not accepted; 544 writes of 0x1F20 to ada 0..543; char_ready=0 until done; cursor 0,0.
5. Cursor 5,0 send 0x08, then 0x0D, then 0x07 → no RAM writes; cursor stays 5,0; all three bytes consumed.
6. Assert reset at clear word 100 → next cycle ram_cea=0, state IDLE, char_ready=1, cursor 0,0.
